fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Pipelined IEEE-style floating-point add/subtract: operand capture, then align, add and
// normalise/round/pack stages; denormals flush to zero. Optional flags output: FP_ADDSUB_PIPE_FLAGS_EN.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam logic [EXP_W-1:0]        EXP_MAX = '1;
  localparam logic signed [EXP_W+1:0] EXP_TOP = {2'b00, EXP_MAX};
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

  typedef enum logic [1:0] {K_NUM = 2'd0, K_INF = 2'd1, K_NAN = 2'd2} kind_e;

  // Stage registers
  logic                v0_q, v0_d, op0_q, op0_d;
  logic [W-1:0]        a0_q, a0_d, b0_q, b0_d;
  logic                v1_q, v1_d, sign1_q, sign1_d, eop1_q, eop1_d;
  kind_e               kind1_q, kind1_d;
  logic [EXP_W-1:0]    exp1_q, exp1_d;
  logic [SW-1:0]       big1_q, big1_d, small1_q, small1_d;
  logic                v2_q, v2_d, sign2_q, sign2_d;
  kind_e               kind2_q, kind2_d;
  logic [EXP_W-1:0]    exp2_q, exp2_d;
  logic [SW:0]         sum2_q, sum2_d;
  logic                out_valid_q, out_valid_d;
  logic [W-1:0]        z_q, z_d;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
  logic                inv1_q, inv1_d, inv2_q, inv2_d;
  logic [3:0]          flags_q, flags_d, flag_res;
`endif

  // Stage 1 combinational signals
  logic                sa, sb_eff, eop, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
  logic [EXP_W-1:0]    ea, eb, e_big, e_diff;
  logic [MAN_W-1:0]    ma, mb;
  logic [SW-1:0]       sig_a, sig_b, sig_big, sig_small, small_al, sh_mask;
  logic                sign_num;

  // Stage 3 combinational signals
  int                  lead, shift;
  logic [SW-1:0]       norm;
  logic signed [EXP_W+1:0] exp_n, exp_f;
  logic                rnd_up;
  logic [MAN_W:0]      mant_r;
  logic [W-1:0]        z_res;

  logic advance;
  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign z         = z_q;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
  assign flags     = flags_q;
`endif

  // Operand capture
  always_comb begin
    // NOTE: every combinationally driven variable gets a default first so no path infers a latch.
    v0_d  = v0_q;
    op0_d = op0_q;
    a0_d  = a0_q;
    b0_d  = b0_q;
    if (advance) begin
      v0_d  = in_valid;
      op0_d = op;
      a0_d  = a;
      b0_d  = b;
    end
  end

  // S1: unpack, classify, magnitude compare, align smaller operand
  always_comb begin
    sa     = a0_q[W-1];
    sb_eff = b0_q[W-1] ^ op0_q;
    eop    = sa ^ sb_eff;
    ea     = a0_q[W-2 -: EXP_W];
    eb     = b0_q[W-2 -: EXP_W];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    ma     = a0_q[MAN_W-1:0] & {MAN_W{~a_zero}};
    mb     = b0_q[MAN_W-1:0] & {MAN_W{~b_zero}};
    a_inf  = (ea == EXP_MAX) && (ma == '0);
    b_inf  = (eb == EXP_MAX) && (mb == '0);
    a_nan  = (ea == EXP_MAX) && (ma != '0);
    b_nan  = (eb == EXP_MAX) && (mb != '0);
    sig_a  = {~a_zero, ma, 3'b000};
    sig_b  = {~b_zero, mb, 3'b000};
    a_ge_b = {ea, ma} >= {eb, mb};
    if (a_ge_b) begin
      e_big = ea; e_diff = ea - eb; sig_big = sig_a; sig_small = sig_b; sign_num = sa;
    end else begin
      e_big = eb; e_diff = eb - ea; sig_big = sig_b; sig_small = sig_a; sign_num = sb_eff;
    end
    sh_mask = '0;
    if (32'(e_diff) >= SW - 1) begin
      small_al = {{(SW-1){1'b0}}, |sig_small};
    end else begin
      sh_mask  = ~({SW{1'b1}} << e_diff);
      small_al = (sig_small >> e_diff) | {{(SW-1){1'b0}}, |(sig_small & sh_mask)};
    end

    v1_d     = v1_q;
    kind1_d  = kind1_q;
    sign1_d  = sign1_q;
    eop1_d   = eop1_q;
    exp1_d   = exp1_q;
    big1_d   = big1_q;
    small1_d = small1_q;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    inv1_d   = inv1_q;
`endif
    if (advance) begin
      v1_d     = v0_q;
      eop1_d   = eop;
      exp1_d   = e_big;
      big1_d   = sig_big;
      small1_d = small_al;
      sign1_d  = sign_num;
      kind1_d  = K_NUM;
      if (a_nan || b_nan || (a_inf && b_inf && eop)) begin
        kind1_d = K_NAN;
      end else if (a_inf || b_inf) begin
        kind1_d = K_INF;
        sign1_d = a_inf ? sa : sb_eff;
      end
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
      inv1_d = a_inf && b_inf && eop;
`endif
    end
  end

  // S2: mantissa add/subtract; the larger operand is always on the left so the result is non-negative
  always_comb begin
    v2_d    = v2_q;
    kind2_d = kind2_q;
    sign2_d = sign2_q;
    exp2_d  = exp2_q;
    sum2_d  = sum2_q;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    inv2_d  = inv2_q;
`endif
    if (advance) begin
      v2_d    = v1_q;
      kind2_d = kind1_q;
      sign2_d = sign1_q;
      exp2_d  = exp1_q;
      sum2_d  = eop1_q ? ({1'b0, big1_q} - {1'b0, small1_q})
                       : ({1'b0, big1_q} + {1'b0, small1_q});
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
      inv2_d  = inv1_q;
`endif
    end
  end

  // S3: normalise, round to nearest even, pack and handle specials
  always_comb begin
    lead = 0;
    for (int i = 0; i < SW; i++) begin
      if (sum2_q[i]) lead = i;
    end
    shift = SW - 1 - lead;
    if (sum2_q[SW]) begin
      norm  = sum2_q[SW:1] | {{(SW-1){1'b0}}, sum2_q[0]};
      exp_n = $signed({2'b00, exp2_q}) + EXP_ONE;
    end else begin
      norm  = sum2_q[SW-1:0] << shift;
      exp_n = $signed({2'b00, exp2_q}) - $signed((EXP_W+2)'(shift));
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r = {1'b0, norm[SW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
    exp_f  = exp_n + $signed({{(EXP_W+1){1'b0}}, mant_r[MAN_W]});

    z_res = '0;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    flag_res = 4'b0000;
`endif
    case (kind2_q)
      K_NAN: begin
        z_res = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
        flag_res = {inv2_q, 3'b000};
`endif
      end
      K_INF: z_res = {sign2_q, EXP_MAX, {MAN_W{1'b0}}};
      default: begin
        // norm's top bit is clear only when the sum was exactly zero
        if (!norm[SW-1]) begin
          z_res = '0;
        end else if (exp_f < EXP_ONE) begin
          z_res = '0;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
          flag_res = 4'b0011;
`endif
        end else if (exp_f >= EXP_TOP) begin
          z_res = {sign2_q, EXP_MAX, {MAN_W{1'b0}}};
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
          flag_res = 4'b0101;
`endif
        end else begin
          z_res = {sign2_q, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
          flag_res = {3'b000, |norm[2:0]};
`endif
        end
      end
    endcase

    out_valid_d = out_valid_q;
    z_d         = z_q;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    flags_d     = flags_q;
`endif
    if (advance) begin
      out_valid_d = v2_q;
      z_d         = z_res;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
      flags_d     = flag_res;
`endif
    end
  end

  // Datapath registers are reset too so z reads 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0; op0_q <= 1'b0; a0_q <= '0; b0_q <= '0;
      v1_q <= 1'b0; kind1_q <= K_NUM; sign1_q <= 1'b0; eop1_q <= 1'b0;
      exp1_q <= '0; big1_q <= '0; small1_q <= '0;
      v2_q <= 1'b0; kind2_q <= K_NUM; sign2_q <= 1'b0; exp2_q <= '0; sum2_q <= '0;
      out_valid_q <= 1'b0; z_q <= '0;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
      inv1_q <= 1'b0; inv2_q <= 1'b0; flags_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking updates so every stage samples the previous stage's old value.
      v0_q <= v0_d; op0_q <= op0_d; a0_q <= a0_d; b0_q <= b0_d;
      v1_q <= v1_d; kind1_q <= kind1_d; sign1_q <= sign1_d; eop1_q <= eop1_d;
      exp1_q <= exp1_d; big1_q <= big1_d; small1_q <= small1_d;
      v2_q <= v2_d; kind2_q <= kind2_d; sign2_q <= sign2_d; exp2_q <= exp2_d; sum2_q <= sum2_d;
      out_valid_q <= out_valid_d; z_q <= z_d;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
      inv1_q <= inv1_d; inv2_q <= inv2_d; flags_q <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: vector table with hand-computed results plus
// stall, reset and latency sequences.
module tb_fp_addsub_pipe;

  logic        clk, rst, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, z;
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
  logic [3:0]  flags;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[20];

  fp_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
  endtask

  task automatic run_one(input int idx, input vec_t v);
    int lat;
    @(posedge clk); #1;
    check($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'd1);
    drive(v.op, v.a, v.b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 10);
    check($sformatf("vec%0d latency", idx), 32'(lat), 32'd3);
    check($sformatf("vec%0d z", idx), z, v.z);
`ifdef FP_ADDSUB_PIPE_FLAGS_EN
    check($sformatf("vec%0d flags", idx), 32'(flags), 32'(v.flg));
`endif
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h3F3504F3, 32'h3FDA827A, 4'b0001};
    vecs[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[2]  = '{1'b1, 32'hBF800000, 32'hBF800000, 32'h00000000, 4'b0000};
    vecs[3]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101};
    vecs[4]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vecs[5]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[6]  = '{1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000};
    vecs[7]  = '{1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000};
    vecs[8]  = '{1'b0, 32'h3F800000, 32'h30800000, 32'h3F800000, 4'b0001};
    vecs[9]  = '{1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000};
    vecs[10] = '{1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000};
    vecs[11] = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000};
    vecs[12] = '{1'b0, 32'h00400000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[13] = '{1'b1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0011};
    vecs[14] = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001};
    vecs[15] = '{1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001};
    vecs[16] = '{1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'b0001};
    vecs[17] = '{1'b0, 32'hBFC00000, 32'hC0200000, 32'hC0800000, 4'b0000};
    vecs[18] = '{1'b1, 32'h40000000, 32'h3FFFFFFF, 32'h34000000, 4'b0000};
    vecs[19] = '{1'b0, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0000};

    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset z", z, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 20; i++) run_one(i, vecs[i]);

    // Back-to-back fill against a stalled consumer, then drain in order
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b0, 32'h3F800000, 32'h3F800000);
    @(posedge clk); #1;
    check("fill in_ready 2", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h40000000, 32'h40000000);
    @(posedge clk); #1;
    check("fill in_ready 3", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h40400000, 32'h40400000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("stall%0d z", c), z, 32'h40000000);
      drive(1'b0, 32'h40A00000, 32'h40A00000);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall end z", z, 32'h40000000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain1 out_valid", 32'(out_valid), 32'd1);
    check("drain1 z", z, 32'h40800000);
    @(posedge clk); #1;
    check("drain2 out_valid", 32'(out_valid), 32'd1);
    check("drain2 z", z, 32'h40C00000);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("drain empty%0d out_valid", c), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset with a held result and two operations in flight
    out_ready = 1'b0;
    drive(1'b0, 32'h3F800000, 32'h3F800000);
    @(posedge clk); #1;
    drive(1'b0, 32'h40000000, 32'h40000000);
    @(posedge clk); #1;
    drive(1'b0, 32'h40400000, 32'h40400000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre-reset out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'd0);
    check("async reset z", z, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("post-reset%0d out_valid", c), 32'(out_valid), 32'd0);
    end
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    run_one(100, '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
